// File: rtl/des_core_arbiter.sv
// Round-robin arbiter sharing one iterative DES engine between two requesters,
// with per-requester response slots and a watchdog on every engine job.
module des_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_decrypt,
  input  logic [63:0] req0_key,
  input  logic [63:0] req0_text,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_decrypt,
  input  logic [63:0] req1_key,
  input  logic [63:0] req1_text,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_data,
  output logic        rsp0_error,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_data,
  output logic        rsp1_error,
  output logic        core_start_encrypt,
  output logic        core_start_decrypt,
  output logic [63:0] core_key,
  output logic [63:0] core_text,
  input  logic        core_done_encrypt,
  input  logic        core_done_decrypt,
  input  logic [63:0] core_output_text,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // The timer reads 0 in the first RUN cycle, so aborting when it holds
  // TIMEOUT_CYCLES-2 registers the error response TIMEOUT_CYCLES after accept.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 2);

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic [7:0] timer;
  logic       elig0;
  logic       elig1;
  logic       grant_sel;
  logic       accept;
  logic       match_done;
  logic       wrong_done;
  logic       finish_ok;
  logic       finish_err;

  assign elig0      = req0_valid && !rsp0_valid;
  assign elig1      = req1_valid && !rsp1_valid;
  assign grant_sel  = (elig0 && elig1) ? ~last_grant : elig1;
  assign req0_ready = (state == IDLE) && elig0 && !grant_sel;
  assign req1_ready = (state == IDLE) && elig1 && grant_sel;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  assign match_done = core_start_decrypt ? core_done_decrypt : core_done_encrypt;
  assign wrong_done = core_start_decrypt ? core_done_encrypt : core_done_decrypt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (match_done) begin
          finish_ok  = 1'b1;
          state_next = DRAIN;
        end else if (wrong_done || (timer == TIMER_LAST)) begin
          finish_err = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A done still high belongs to the job just finished, never the next.
        if (!core_done_encrypt && !core_done_decrypt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant         <= 1'b1;
      grant_id           <= 1'b0;
      timer              <= 8'd0;
      core_start_encrypt <= 1'b0;
      core_start_decrypt <= 1'b0;
      core_key           <= 64'd0;
      core_text          <= 64'd0;
      rsp0_valid         <= 1'b0;
      rsp0_error         <= 1'b0;
      rsp0_data          <= 64'd0;
      rsp1_valid         <= 1'b0;
      rsp1_error         <= 1'b0;
      rsp1_data          <= 64'd0;
    end else begin
      if (accept) begin
        grant_id           <= grant_sel;
        last_grant         <= grant_sel;
        timer              <= 8'd0;
        core_key           <= grant_sel ? req1_key : req0_key;
        core_text          <= grant_sel ? req1_text : req0_text;
        core_start_decrypt <= grant_sel ? req1_decrypt : req0_decrypt;
        core_start_encrypt <= grant_sel ? !req1_decrypt : !req0_decrypt;
      end
      if (state == RUN) timer <= timer + 8'd1;
      if (finish_ok || finish_err) begin
        core_start_encrypt <= 1'b0;
        core_start_decrypt <= 1'b0;
      end

      if (rsp0_valid && rsp0_ready) begin
        rsp0_valid <= 1'b0;
        rsp0_error <= 1'b0;
        rsp0_data  <= 64'd0;
      end
      if ((finish_ok || finish_err) && !grant_id) begin
        rsp0_valid <= 1'b1;
        rsp0_error <= finish_err;
        rsp0_data  <= finish_ok ? core_output_text : 64'd0;
      end

      if (rsp1_valid && rsp1_ready) begin
        rsp1_valid <= 1'b0;
        rsp1_error <= 1'b0;
        rsp1_data  <= 64'd0;
      end
      if ((finish_ok || finish_err) && grant_id) begin
        rsp1_valid <= 1'b1;
        rsp1_error <= finish_err;
        rsp1_data  <= finish_ok ? core_output_text : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_des_core_arbiter.sv
// Bench for des_core_arbiter: a timed DES engine stub plus a scenario task per
// feature, each comparing against expectations built from the arbiter's rules.
module tb_des_core_arbiter;

  localparam logic [63:0] KEY_V = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_V  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_V  = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_decrypt;
  logic [63:0] req0_key, req0_text;
  logic        req1_valid, req1_ready, req1_decrypt;
  logic [63:0] req1_key, req1_text;
  logic        rsp0_valid, rsp0_ready, rsp0_error;
  logic [63:0] rsp0_data;
  logic        rsp1_valid, rsp1_ready, rsp1_error;
  logic [63:0] rsp1_data;
  logic        core_start_encrypt, core_start_decrypt;
  logic [63:0] core_key, core_text;
  logic        core_done_encrypt, core_done_decrypt;
  logic [63:0] core_output_text;
  logic        busy, grant_id;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stub_mode = 0;  // 0 normal, 1 never done, 2 fires the opposite done
  int run_cnt, low_cnt;

  typedef struct {
    logic [63:0] k;
    logic [63:0] t;
    logic        d;
    int          c;
  } job_t;

  des_core_arbiter #(.TIMEOUT_CYCLES(30)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_decrypt(req0_decrypt),
    .req0_key(req0_key), .req0_text(req0_text),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_decrypt(req1_decrypt),
    .req1_key(req1_key), .req1_text(req1_text),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_error(rsp1_error),
    .core_start_encrypt(core_start_encrypt), .core_start_decrypt(core_start_decrypt),
    .core_key(core_key), .core_text(core_text),
    .core_done_encrypt(core_done_encrypt), .core_done_decrypt(core_done_decrypt),
    .core_output_text(core_output_text),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Known DES vector pair; any other operand gets a cheap reversible stand-in.
  function automatic logic [63:0] ref_des(input logic [63:0] k, input logic [63:0] t,
                                          input logic d);
    if (!d && k == KEY_V && t == PT_V) return CT_V;
    if (d && k == KEY_V && t == CT_V) return PT_V;
    return t ^ {k[31:0], k[63:32]} ^ (d ? 64'hA5A5A5A5A5A5A5A5 : 64'h5A5A5A5A5A5A5A5A);
  endfunction

  // Engine stub: done 20 cycles after start rises, cleared 2 cycles after it falls.
  always @(posedge clk) begin
    if (rst) begin
      core_done_encrypt <= 1'b0;
      core_done_decrypt <= 1'b0;
      core_output_text  <= 64'd0;
      run_cnt <= 0;
      low_cnt <= 0;
    end else if (core_start_encrypt || core_start_decrypt) begin
      low_cnt <= 0;
      run_cnt <= run_cnt + 1;
      if (run_cnt + 1 == 20 && stub_mode != 1) begin
        if (core_start_decrypt ^ (stub_mode == 2)) core_done_decrypt <= 1'b1;
        else core_done_encrypt <= 1'b1;
        core_output_text <= ref_des(core_key, core_text, core_start_decrypt);
      end
    end else begin
      run_cnt <= 0;
      if (core_done_encrypt || core_done_decrypt) begin
        low_cnt <= low_cnt + 1;
        if (low_cnt + 1 == 2) begin
          core_done_encrypt <= 1'b0;
          core_done_decrypt <= 1'b0;
          low_cnt <= 0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req0_decrypt = 0; req0_key = 0; req0_text = 0;
    req1_valid = 0; req1_decrypt = 0; req1_key = 0; req1_text = 0;
    rsp0_ready = 0; rsp1_ready = 0; stub_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_job(input int id, input logic [63:0] k, input logic [63:0] t,
                          input logic d, output int acc);
    acc = -1;
    @(posedge clk); #1;
    if (id == 0) begin req0_key = k; req0_text = t; req0_decrypt = d; req0_valid = 1; end
    else         begin req1_key = k; req1_text = t; req1_decrypt = d; req1_valid = 1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic wait_rsp(input int id, output int c, output logic [63:0] data,
                          output logic err);
    c = -1; data = 'x; err = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((id == 0) ? rsp0_valid : rsp1_valid) begin
        c = cyc;
        data = (id == 0) ? rsp0_data : rsp1_data;
        err  = (id == 0) ? rsp0_error : rsp1_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({rsp0_valid, rsp1_valid, rsp0_error, rsp1_error, core_start_encrypt,
         core_start_decrypt, busy, grant_id, req0_ready, req1_ready} !== 10'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags got %b want 0", {rsp0_valid, rsp1_valid, rsp0_error,
               rsp1_error, core_start_encrypt, core_start_decrypt, busy, grant_id,
               req0_ready, req1_ready});
    end
    tests++;
    if ({rsp0_data, rsp1_data, core_key, core_text} !== 256'd0) begin
      fails++;
      $display("[TB] FAIL reset_data got %h %h %h %h want 0", rsp0_data, rsp1_data,
               core_key, core_text);
    end
  endtask

  task automatic test_encrypt();
    int acc, c;
    logic [63:0] data;
    logic err;
    logic [2:0] busy_seen;
    rsp0_ready = 1;
    send_job(0, KEY_V, PT_V, 1'b0, acc);
    wait_rsp(0, c, data, err);
    tests++;
    if (acc < 0 || c - acc !== 22) begin
      fails++; $display("[TB] FAIL enc_latency got %0d want 22 (acc %0d)", c - acc, acc);
    end
    tests++;
    if (data !== CT_V || err !== 1'b0) begin
      fails++; $display("[TB] FAIL enc_data got %h err %b want %h err 0", data, err, CT_V);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      busy_seen[i] = busy;
    end
    tests++;
    if (busy_seen !== 3'b011) begin
      fails++; $display("[TB] FAIL enc_drain busy got %b want 011", busy_seen);
    end
  endtask

  task automatic test_decrypt();
    int acc, c;
    logic [63:0] data;
    logic err;
    rsp1_ready = 1;
    send_job(1, KEY_V, CT_V, 1'b1, acc);
    @(negedge clk);
    tests++;
    if (core_start_decrypt !== 1'b1 || core_start_encrypt !== 1'b0 || grant_id !== 1'b1) begin
      fails++;
      $display("[TB] FAIL dec_start got d%b e%b g%b want d1 e0 g1", core_start_decrypt,
               core_start_encrypt, grant_id);
    end
    wait_rsp(1, c, data, err);
    tests++;
    if (acc < 0 || c - acc !== 22 || data !== PT_V || err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL dec_data got %h err %b lat %0d want %h err 0 lat 22",
               data, err, c - acc, PT_V);
    end
  endtask

  task automatic test_contention();
    job_t pend[2];
    int prev, done_n, id;
    logic got0, got1;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    @(posedge clk); #1;
    req0_key = {$urandom, $urandom}; req0_text = {$urandom, $urandom};
    req0_decrypt = 1'($urandom_range(0, 1)); req0_valid = 1;
    req1_key = {$urandom, $urandom}; req1_text = {$urandom, $urandom};
    req1_decrypt = 1'($urandom_range(0, 1)); req1_valid = 1;
    prev = 1;
    done_n = 0;
    for (int n = 0; n < 400 && done_n < 8; n++) begin
      @(negedge clk);
      got0 = 0; got1 = 0;
      if (req0_ready || req1_ready) begin
        id = req1_ready ? 1 : 0;
        tests++;
        if (id != 1 - prev || (req0_ready && req1_ready)) begin
          fails++;
          $display("[TB] FAIL rr_grant got %0d (r0 %b r1 %b) want %0d", id, req0_ready,
                   req1_ready, 1 - prev);
        end
        if (id == 0) begin pend[0] = '{req0_key, req0_text, req0_decrypt, cyc}; got0 = 1; end
        else         begin pend[1] = '{req1_key, req1_text, req1_decrypt, cyc}; got1 = 1; end
        prev = id;
      end
      if (rsp0_valid) begin
        tests++;
        if (rsp0_data !== ref_des(pend[0].k, pend[0].t, pend[0].d) || rsp0_error !== 1'b0 ||
            cyc - pend[0].c != 22) begin
          fails++;
          $display("[TB] FAIL rr_rsp0 got %h err %b lat %0d want %h err 0 lat 22", rsp0_data,
                   rsp0_error, cyc - pend[0].c, ref_des(pend[0].k, pend[0].t, pend[0].d));
        end
        done_n++;
      end
      if (rsp1_valid) begin
        tests++;
        if (rsp1_data !== ref_des(pend[1].k, pend[1].t, pend[1].d) || rsp1_error !== 1'b0 ||
            cyc - pend[1].c != 22) begin
          fails++;
          $display("[TB] FAIL rr_rsp1 got %h err %b lat %0d want %h err 0 lat 22", rsp1_data,
                   rsp1_error, cyc - pend[1].c, ref_des(pend[1].k, pend[1].t, pend[1].d));
        end
        done_n++;
      end
      @(posedge clk); #1;
      if (got0) begin
        req0_key = {$urandom, $urandom}; req0_text = {$urandom, $urandom};
        req0_decrypt = 1'($urandom_range(0, 1));
      end
      if (got1) begin
        req1_key = {$urandom, $urandom}; req1_text = {$urandom, $urandom};
        req1_decrypt = 1'($urandom_range(0, 1));
      end
    end
    tests++;
    if (done_n < 8) begin
      fails++; $display("[TB] FAIL rr_count got %0d responses want 8", done_n);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int acc, c, hold_bad;
    logic [63:0] data, exp1, k2, t2;
    logic err;
    do_reset();
    rsp0_ready = 0;
    exp1 = ref_des(64'h0F1E2D3C4B5A6978, 64'h1122334455667788, 1'b0);
    send_job(0, 64'h0F1E2D3C4B5A6978, 64'h1122334455667788, 1'b0, acc);
    wait_rsp(0, c, data, err);
    tests++;
    if (c < 0 || data !== exp1 || err !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_first got %h err %b want %h err 0", data, err, exp1);
    end
    @(posedge clk); #1;
    k2 = {$urandom, $urandom}; t2 = {$urandom, $urandom};
    req0_key = k2; req0_text = t2; req0_decrypt = 1; req0_valid = 1;
    hold_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_data !== exp1) hold_bad++;
    end
    tests++;
    if (hold_bad != 0) begin
      fails++; $display("[TB] FAIL bp_hold got %0d bad cycles want 0", hold_bad);
    end
    @(posedge clk); #1 rsp0_ready = 1;
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_same_cycle got ready %b want 0", req0_ready);
    end
    @(posedge clk); #1 rsp0_ready = 0;
    @(negedge clk);
    acc = cyc;
    tests++;
    if (req0_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_next_cycle got ready %b valid %b want 1 0", req0_ready, rsp0_valid);
    end
    @(posedge clk); #1 req0_valid = 0; rsp0_ready = 1;
    wait_rsp(0, c, data, err);
    tests++;
    if (c - acc != 22 || data !== ref_des(k2, t2, 1'b1) || err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_second got %h err %b lat %0d want %h err 0 lat 22", data, err,
               c - acc, ref_des(k2, t2, 1'b1));
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_wrong_done();
    int acc, c;
    logic [63:0] data;
    logic err;
    stub_mode = 2; rsp0_ready = 1;
    send_job(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, acc);
    wait_rsp(0, c, data, err);
    tests++;
    if (acc < 0 || c - acc != 22 || data !== 64'd0 || err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrong_done got %h err %b lat %0d want 0 err 1 lat 22", data, err,
               c - acc);
    end
    repeat (5) @(posedge clk);
    #1 stub_mode = 0;
  endtask

  task automatic test_timeout();
    int acc, c;
    logic [63:0] data;
    logic err;
    stub_mode = 1; rsp0_ready = 1;
    send_job(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc);
    wait_rsp(0, c, data, err);
    tests++;
    if (acc < 0 || c - acc != 30 || data !== 64'd0 || err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout got %h err %b lat %0d want 0 err 1 lat 30", data, err,
               c - acc);
    end
    tests++;
    if (busy !== 1'b1 || core_start_decrypt !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_drain got busy %b start %b want 1 0", busy, core_start_decrypt);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_idle got busy %b want 0", busy);
    end
    @(posedge clk); #1 stub_mode = 0;
  endtask

  task automatic test_reset_mid_run();
    int acc, c;
    logic [63:0] data, k, t;
    logic err;
    rsp0_ready = 1; rsp1_ready = 1;
    send_job(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, acc);
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    tests++;
    if ({rsp0_valid, rsp1_valid, rsp0_error, rsp1_error, core_start_encrypt,
         core_start_decrypt, busy, grant_id} !== 8'b0 ||
        {rsp0_data, rsp1_data, core_key, core_text} !== 256'd0) begin
      fails++;
      $display("[TB] FAIL midrun_reset got busy %b start %b%b key %h want all 0", busy,
               core_start_encrypt, core_start_decrypt, core_key);
    end
    k = {$urandom, $urandom}; t = {$urandom, $urandom};
    @(posedge clk); #1;
    req0_key = k; req0_text = t; req0_decrypt = 0; req0_valid = 1;
    req1_key = ~k; req1_text = ~t; req1_decrypt = 1; req1_valid = 1;
    @(negedge clk);
    acc = cyc;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_tie got r0 %b r1 %b want 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    wait_rsp(0, c, data, err);
    tests++;
    if (c - acc != 22 || data !== ref_des(k, t, 1'b0) || err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_job got %h err %b lat %0d want %h err 0 lat 22", data, err,
               c - acc, ref_des(k, t, 1'b0));
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_contention();
    test_backpressure();
    test_wrong_done();
    test_timeout();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
